// File: rtl/skid_buffer_sync_rstn.sv
// Two-entry valid/ready skid buffer with registered m_valid, m_data and s_ready.
// Optional stall counter output enabled by defining SKID_BUFFER_STALL_CNT_EN.
module skid_buffer_sync_rstn #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
`ifdef SKID_BUFFER_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] skid_q;
   logic             load_out;
   logic             load_skid;
   logic             out_from_skid;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // The skid register only fills when a beat arrives while the output is stalled.
   always_comb begin
      next_state    = state;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (s_valid) begin
               load_out   = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            if (s_valid && m_ready) begin
               load_out = 1'b1;
            end else if (s_valid) begin
               load_skid  = 1'b1;
               next_state = FULL;
            end else if (m_ready) begin
               next_state = EMPTY;
            end
         end
         FULL: begin
            if (m_ready) begin
               load_out      = 1'b1;
               out_from_skid = 1'b1;
               next_state    = BUSY;
            end
         end
         default: begin
            next_state = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_q  <= RESET_VAL;
         skid_q <= RESET_VAL;
      end else begin
         if (load_out) begin
            out_q <= out_from_skid ? skid_q : s_data;
         end
         if (load_skid) begin
            skid_q <= s_data;
         end
      end
   end

   assign s_ready = (state != FULL);
   assign m_valid = (state != EMPTY);
   assign m_data  = out_q;

`ifdef SKID_BUFFER_STALL_CNT_EN
   // Saturating count of cycles the output is held by downstream backpressure.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (m_valid && !m_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_skid_buffer_sync_rstn.sv
// Self-checking bench for skid_buffer_sync_rstn: queue-based reference model plus directed literals.
// Also checks the stall counter when SKID_BUFFER_STALL_CNT_EN is defined.
module tb_skid_buffer_sync_rstn;

   localparam int         WIDTH = 8;
   localparam logic [7:0] RVAL  = 8'h3C;

   logic             clk;
   logic             rstn;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
`ifdef SKID_BUFFER_STALL_CNT_EN
   logic [31:0]      stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   skid_buffer_sync_rstn #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RVAL)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data)
`ifdef SKID_BUFFER_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
      end
   endtask

   // Model: the buffer is a FIFO of at most two beats; the head is what m_data shows.
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] last_out;
   bit               emitted;
   bit               model_live = 0;
   logic [31:0]      model_stall;

   always @(posedge clk) begin
      if (!rstn) begin
         mq.delete();
         last_out    = RVAL;
         emitted     = 0;
         model_stall = 0;
         model_live  = 1;
      end else if (model_live) begin
         bit can_take;
         can_take = (mq.size() < 2);
         if (mq.size() > 0 && !m_ready && model_stall != 32'hFFFF_FFFF) model_stall++;
         if (mq.size() > 0 && m_ready) begin
            last_out = mq.pop_front();
            emitted  = 1;
         end
         if (s_valid && can_take) mq.push_back(s_data);
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("model m_valid", {31'd0, m_valid}, {31'd0, (mq.size() > 0)});
         check("model s_ready", {31'd0, s_ready}, {31'd0, (mq.size() < 2)});
         if (mq.size() > 0)
            check("model m_data", {24'd0, m_data}, {24'd0, mq[0]});
         else if (!emitted)
            check("model m_data after reset", {24'd0, m_data}, {24'd0, last_out});
`ifdef SKID_BUFFER_STALL_CNT_EN
         check("model stall_cnt", stall_cnt, model_stall);
`endif
      end
   end

   task automatic applyStimulus(input logic rst_n, input logic sv, input logic [WIDTH-1:0] sd, input logic mr);
      rstn    = rst_n;
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic exp_valid, input logic exp_ready, input logic [WIDTH-1:0] exp_data);
      check({name, " m_valid"}, {31'd0, m_valid}, {31'd0, exp_valid});
      check({name, " s_ready"}, {31'd0, s_ready}, {31'd0, exp_ready});
      if (exp_valid || name == "reset" || name == "idle" || name == "midreset")
         check({name, " m_data"}, {24'd0, m_data}, {24'd0, exp_data});
   endtask

   initial begin
      rstn    = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;

      $display("[TB] reset and idle");
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("reset", 1'b0, 1'b1, RVAL);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
         checkOutput("idle", 1'b0, 1'b1, RVAL);
      end

      $display("[TB] streaming");
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b1, 1'b1, 8'(i), 1'b1);
         checkOutput("stream", 1'b1, 1'b1, 8'(i));
      end
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput("drain", 1'b0, 1'b1, 8'h00);

      $display("[TB] backpressure and skid");
      applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0);
      checkOutput("skid busy", 1'b1, 1'b1, 8'hA1);
      applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0);
      checkOutput("skid full", 1'b1, 1'b0, 8'hA1);
      applyStimulus(1'b1, 1'b1, 8'hA3, 1'b0);
      checkOutput("skid refuse", 1'b1, 1'b0, 8'hA1);
      applyStimulus(1'b1, 1'b1, 8'hA3, 1'b1);
      checkOutput("skid out2", 1'b1, 1'b1, 8'hA2);
      applyStimulus(1'b1, 1'b1, 8'hA3, 1'b1);
      checkOutput("skid out3", 1'b1, 1'b1, 8'hA3);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput("skid empty", 1'b0, 1'b1, 8'h00);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 1'b1, 8'hB1, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'hB2, 1'b0);
      checkOutput("midfull", 1'b1, 1'b0, 8'hB1);
      applyStimulus(1'b0, 1'b1, 8'hB3, 1'b1);
      checkOutput("midreset", 1'b0, 1'b1, RVAL);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput("midreset", 1'b0, 1'b1, RVAL);

      $display("[TB] random traffic");
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput("final drain", 1'b0, 1'b1, 8'h00);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
